// File: rtl/serial_add2_seq.sv
// Digit-serial adder: two bits of a+b+cin per clock through a 2-bit ripple slice,
// with a valid/ready handshake on both the operand and the result side.
module serial_add2_seq #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned Digits = W / 2;
    localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0]      a_dig, b_dig;
    logic            s0, s1, c1, c2;
    logic [W-1:0]    dig_mask, dig_val;
    logic            last_dig;

    // Current digit slice and its placement in the sum register.
    always_comb begin
        a_dig    = 2'(a_q >> (2 * cnt_q));
        b_dig    = 2'(b_q >> (2 * cnt_q));
        s0       = a_dig[0] ^ b_dig[0] ^ carry_q;
        c1       = (a_dig[0] & b_dig[0]) | (a_dig[0] & carry_q) | (b_dig[0] & carry_q);
        s1       = a_dig[1] ^ b_dig[1] ^ c1;
        c2       = (a_dig[1] & b_dig[1]) | (a_dig[1] & c1) | (b_dig[1] & c1);
        dig_mask = W'(2'b11) << (2 * cnt_q);
        dig_val  = W'({s1, s0}) << (2 * cnt_q);
        last_dig = (cnt_q == CntW'(Digits - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = (sum_q & ~dig_mask) | dig_val;
                carry_d = c2;
                // Counter parks on the last digit instead of wrapping.
                if (last_dig) begin
                    cout_d  = c2;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add2_seq.sv
// Directed bench for serial_add2_seq: a W=16 instance for latency, backpressure, input
// isolation and reset abort, and a W=2 instance swept over every operand combination.
module tb_serial_add2_seq;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
    logic [1:0]  a2, b2, sum2;

    int n_vec;
    int n_err;

    serial_add2_seq #(.W(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    serial_add2_seq #(.W(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .a        (a2),
        .b        (b2),
        .cin      (cin2),
        .out_valid(out_valid2),
        .out_ready(out_ready2),
        .sum      (sum2),
        .cout     (cout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operand set, check exact 8-cycle latency and the result, then drain it.
    task automatic run16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            if (i == 7) check({tag, "_early"}, out_valid, 1'b0);
        end
        step();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle"}, in_ready, 1'b1);
        check({tag, "_hold"}, sum, es);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a2         = '0;
        b2         = '0;
        cin2       = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);

        run16("ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run16("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        run16("ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run16("aaaa_5555", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);
        run16("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: 0x00FF + 0x0F01 + 1 = 0x1001.
        in_valid = 1'b1;
        a        = 16'h00FF;
        b        = 16'h0F01;
        cin      = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_sum", sum, 16'h1001);
            check("bp_cout", cout, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_idle", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);

        // Inputs toggle while in_valid stays high during RUN: 0x0F0F + 0x00F1 = 0x1000.
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h00F1;
        cin      = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            check("tog_in_ready", in_ready, 1'b0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("tog_valid", out_valid, 1'b1);
        check("tog_sum", sum, 16'h1000);
        check("tog_cout", cout, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("tog_idle", in_ready, 1'b1);

        // Reset on the 3rd RUN cycle aborts the operation.
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum", sum, 16'h0000);
        for (int i = 0; i < 9; i++) step();
        check("abort_no_result", out_valid, 1'b0);
        run16("after_abort", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);

        // W=2: one RUN cycle per operation, every a, b, cin combination.
        for (int va = 0; va < 4; va++) begin
            for (int vb = 0; vb < 4; vb++) begin
                for (int vc = 0; vc < 2; vc++) begin
                    in_valid2 = 1'b1;
                    a2        = 2'(va);
                    b2        = 2'(vb);
                    cin2      = 1'(vc);
                    step();
                    in_valid2 = 1'b0;
                    check("w2_busy", out_valid2, 1'b0);
                    step();
                    check("w2_valid", out_valid2, 1'b1);
                    check($sformatf("w2_%0d_%0d_%0d", va, vb, vc), {cout2, sum2},
                          32'(va + vb + vc));
                    out_ready2 = 1'b1;
                    step();
                    out_ready2 = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add2_seq.md
SERIAL_ADD2_SEQ -- requirements
Module: serial_add2_seq

Interface
REQ-001 The module SHALL have parameter W, default 16, giving the operand width in bits; W SHALL be even and at least 2.
REQ-002 The port clk SHALL be an input, 1 bit wide, and the single clock; all state changes on the rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and the reset; reset is synchronous and active-high.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and mark the operand set as valid.
REQ-005 The port in_ready SHALL be an output, 1 bit wide, and mean the block can accept an operand set.
REQ-006 The port a SHALL be an input, W bits wide, and carry operand A.
REQ-007 The port b SHALL be an input, W bits wide, and carry operand B.
REQ-008 The port cin SHALL be an input, 1 bit wide, and carry the carry-in.
REQ-009 The port out_valid SHALL be an output, 1 bit wide, and mean the result is valid.
REQ-010 The port out_ready SHALL be an input, 1 bit wide, and mean the consumer takes the result.
REQ-011 The port sum SHALL be an output, W bits wide, and carry the result sum, (a+b+cin) mod 2^W.
REQ-012 The port cout SHALL be an output, 1 bit wide, and carry the carry-out of a+b+cin.

Function
REQ-013 The block SHALL be a digit-serial adder processing 2 bits per cycle through a 2-bit ripple slice: s0=a0^b0^c; c1=maj(a0,b0,c); s1=a1^b1^c1; c2=maj(a1,b1,c1).
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-016 Accept SHALL occur when in_valid&in_ready is high at an edge: latch a, b; carry<=cin; digit counter<=0; sum register<=0; state<=RUN.
REQ-017 Each RUN cycle SHALL process digit k = counter, using bits [2k+1:2k] of latched a, b and the carry register, then write s1,s0 to sum[2k+1:2k], set carry<=c2 and increment the counter.
REQ-018 On the edge processing digit W/2-1, the block SHALL enter DONE with cout = final c2 and no counter wrap.
REQ-019 Latency SHALL be exactly W/2 cycles: out_valid is first high after the W/2-th edge following the accept edge.
REQ-020 In DONE, sum and cout SHALL stay stable while out_ready=0 (backpressure of any length).
REQ-021 DONE&out_ready SHALL cause transition to IDLE on that edge; sum/cout hold their values until the next accept.
REQ-022 in_valid, a, b and cin SHALL be ignored outside IDLE; changes to them during RUN SHALL not affect the result.
REQ-023 Throughput SHALL be one operation per W/2+2 cycles minimum, with no overlap of accept and result.
REQ-024 For W=2, RUN SHALL last one cycle and the result SHALL equal the single-slice function.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, counter 0, carry 0, sum 0, cout 0, in_ready 1 and out_valid 0.
REQ-026 rst SHALL take priority over any handshake in the same cycle; reset during RUN or DONE SHALL discard the operation and emit no result.

Verification
REQ-027 W=16, a=0xFFFF, b=0x0001, cin=0 -> after 8 cycles out_valid=1, sum=0x0000, cout=1.
REQ-028 W=16, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, out_valid exactly 8 cycles after accept.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout are constant; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-030 Toggle a and b while in_valid=1 during RUN -> no second accept and the result matches the first operands only.
REQ-031 Assert rst at the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a new operation completes correctly.
REQ-032 W=2, all 32 combinations of a, b and cin -> {cout,sum} equals a+b+cin after 1 cycle each.
